// File: rtl/upe_negate16.sv
// Dual-lane 16-bit two's-complement negation with one registered output stage.
// Optional build macro UPE_NEGATE_SATURATE_EN: 16'h8000 saturates to 16'h7FFF instead of wrapping.
module upe_negate16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] In1,
  input  logic [15:0] In2,
  output logic        out_valid,
  output logic [15:0] Out1,
  output logic [15:0] Out2,
  output logic        ovf1,
  output logic        ovf2
);

  localparam logic [15:0] MinNeg = 16'h8000;
  localparam logic [15:0] MaxPos = 16'h7FFF;

  // The most negative value is the only operand whose negation is not representable.
  function automatic logic lane_ovf(input logic [15:0] a);
    return (a == MinNeg);
  endfunction

  function automatic logic [15:0] lane_negate(input logic [15:0] a);
    logic [15:0] n;
    n = ~a + 16'd1;
`ifdef UPE_NEGATE_SATURATE_EN
    if (lane_ovf(a)) begin
      n = MaxPos;
    end
`endif
    return n;
  endfunction

  logic        valid_d, valid_q;
  logic [15:0] out1_d, out1_q;
  logic [15:0] out2_d, out2_q;
  logic        ovf1_d, ovf1_q;
  logic        ovf2_d, ovf2_q;

  always_comb begin
    valid_d = in_valid;
    out1_d  = out1_q;
    out2_d  = out2_q;
    ovf1_d  = ovf1_q;
    ovf2_d  = ovf2_q;
    // Data and flags hold their last values when no new pair arrives.
    if (in_valid) begin
      out1_d = lane_negate(In1);
      out2_d = lane_negate(In2);
      ovf1_d = lane_ovf(In1);
      ovf2_d = lane_ovf(In2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out1_q  <= 16'h0000;
      out2_q  <= 16'h0000;
      ovf1_q  <= 1'b0;
      ovf2_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      ovf1_q  <= ovf1_d;
      ovf2_q  <= ovf2_d;
    end
  end

  assign out_valid = valid_q;
  assign Out1      = out1_q;
  assign Out2      = out2_q;
  assign ovf1      = ovf1_q;
  assign ovf2      = ovf2_q;

endmodule

// File: tb/tb_upe_negate16.sv
// Self-checking bench for upe_negate16: directed steps plus random traffic against
// an arithmetic reference model; honours UPE_NEGATE_SATURATE_EN like the design.
module tb_upe_negate16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] In1;
  logic [15:0] In2;
  logic        out_valid;
  logic [15:0] Out1;
  logic [15:0] Out2;
  logic        ovf1;
  logic        ovf2;

  int checks;
  int failures;

  // Expected output state, kept by the model.
  logic        m_valid;
  logic [15:0] m_out1, m_out2;
  logic        m_ovf1, m_ovf2;

  upe_negate16 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .In1      (In1),
    .In2      (In2),
    .out_valid(out_valid),
    .Out1     (Out1),
    .Out2     (Out2),
    .ovf1     (ovf1),
    .ovf2     (ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 0 - x in plain integer arithmetic, then fold back to 16 bits.
  function automatic logic [15:0] ref_neg(input logic [15:0] x);
    int v;
    v = 0 - int'($signed(x));
    if (v == 32768) begin
`ifdef UPE_NEGATE_SATURATE_EN
      return 16'h7FFF;
`else
      return 16'h8000;
`endif
    end
    return v[15:0];
  endfunction

  function automatic logic ref_ovf(input logic [15:0] x);
    return (int'($signed(x)) == -32768);
  endfunction

  task automatic check_all(input string tag);
    checks++;
    assert (out_valid === m_valid) else begin
      failures++;
      $error("FAIL %s out_valid got=%b exp=%b", tag, out_valid, m_valid);
    end
    checks++;
    assert (Out1 === m_out1) else begin
      failures++;
      $error("FAIL %s Out1 got=%h exp=%h", tag, Out1, m_out1);
    end
    checks++;
    assert (Out2 === m_out2) else begin
      failures++;
      $error("FAIL %s Out2 got=%h exp=%h", tag, Out2, m_out2);
    end
    checks++;
    assert (ovf1 === m_ovf1) else begin
      failures++;
      $error("FAIL %s ovf1 got=%b exp=%b", tag, ovf1, m_ovf1);
    end
    checks++;
    assert (ovf2 === m_ovf2) else begin
      failures++;
      $error("FAIL %s ovf2 got=%b exp=%b", tag, ovf2, m_ovf2);
    end
  endtask

  // Drive one cycle, advance the model, sample 1 ns after the edge and compare.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [15:0] a, input logic [15:0] b);
    rst      = r;
    in_valid = v;
    In1      = a;
    In2      = b;
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b0;
      m_out1  = 16'h0000;
      m_out2  = 16'h0000;
      m_ovf1  = 1'b0;
      m_ovf2  = 1'b0;
    end else if (v) begin
      m_valid = 1'b1;
      m_out1  = ref_neg(a);
      m_out2  = ref_neg(b);
      m_ovf1  = ref_ovf(a);
      m_ovf2  = ref_ovf(b);
    end else begin
      m_valid = 1'b0;
    end
    check_all(tag);
  endtask

  // Spec-given literal values, checked independently of the model.
  task automatic check_lit(input string tag, input logic [15:0] e1, input logic [15:0] e2);
    checks++;
    assert (Out1 === e1 && Out2 === e2) else begin
      failures++;
      $error("FAIL %s lit got=%h/%h exp=%h/%h", tag, Out1, Out2, e1, e2);
    end
  endtask

  initial begin
    logic [15:0] a, b;
    logic [15:0] sat_val;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    In1      = 16'h0000;
    In2      = 16'h0000;
    m_valid  = 1'b0;
    m_out1   = 16'h0000;
    m_out2   = 16'h0000;
    m_ovf1   = 1'b0;
    m_ovf2   = 1'b0;
`ifdef UPE_NEGATE_SATURATE_EN
    sat_val = 16'h7FFF;
`else
    sat_val = 16'h8000;
`endif

    step("reset0", 1'b1, 1'b1, 16'h1111, 16'h2222);
    step("reset1", 1'b1, 1'b1, 16'h3333, 16'h4444);

    step("basic", 1'b0, 1'b1, 16'hCB2B, 16'hEACF);
    check_lit("basic", 16'h34D5, 16'h1531);
    step("zero_one", 1'b0, 1'b1, 16'h0000, 16'h0001);
    check_lit("zero_one", 16'h0000, 16'hFFFF);
    step("max_m1", 1'b0, 1'b1, 16'h7FFF, 16'hFFFF);
    check_lit("max_m1", 16'h8001, 16'h0001);
    step("ovf_lane1", 1'b0, 1'b1, 16'h8000, 16'h1234);
    check_lit("ovf_lane1", sat_val, 16'hEDCC);
    step("ovf_lane2", 1'b0, 1'b1, 16'h0005, 16'h8000);

    step("stream0", 1'b0, 1'b1, 16'h0102, 16'hA0B0);
    step("stream1", 1'b0, 1'b1, 16'h7000, 16'h8001);
    step("stream2", 1'b0, 1'b1, 16'hFFFE, 16'h8000);
    step("hold0", 1'b0, 1'b0, 16'hDEAD, 16'hBEEF);
    step("hold1", 1'b0, 1'b0, 16'h0000, 16'h8000);

    step("rst_prio", 1'b1, 1'b1, 16'h0001, 16'h0002);
    check_lit("rst_prio", 16'h0000, 16'h0000);
    step("after_rst", 1'b0, 1'b1, 16'h0001, 16'h0002);

    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'h8000;
      if ($urandom_range(0, 7) == 0) b = 16'h8000;
      if ($urandom_range(0, 15) == 0) a = 16'h0000;
      step("random", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
